controle_acesso: RTL and testbench



---
 rtl/acesso_pkg.sv | 44 ++++
 rtl/contador_sessao.sv | 30 +++
 rtl/controle_acesso.sv | 193 +++++++++++++++++++
 tb/tb_controle_acesso.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/acesso_pkg.sv
// Shared definitions for the access controller: profile codes, operation classes,
// state encoding and the profile/operation permission function.
package acesso_pkg;

  localparam logic [2:0] PERFIL_ADM    = 3'b101;
  localparam logic [2:0] PERFIL_TESTER = 3'b110;
  localparam logic [2:0] PERFIL_USER   = 3'b100;
  localparam logic [2:0] PERFIL_GUEST  = 3'b011;
  localparam logic [2:0] PERFIL_NONE   = 3'b000;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_TEST  = 2'd2;
  localparam logic [1:0] OP_ADMIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_LOCKED = 2'b11
  } estado_t;

  function automatic logic perfil_valido(input logic [2:0] p);
    logic ok;
    case (p)
      PERFIL_ADM, PERFIL_TESTER, PERFIL_USER, PERFIL_GUEST: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic permissao(input logic [2:0] p, input logic [1:0] cls);
    logic ok;
    case (cls)
      OP_READ:  ok = perfil_valido(p);
      OP_WRITE: ok = (p == PERFIL_ADM) || (p == PERFIL_TESTER) || (p == PERFIL_USER);
      OP_TEST:  ok = (p == PERFIL_ADM) || (p == PERFIL_TESTER);
      OP_ADMIN: ok = (p == PERFIL_ADM);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/contador_sessao.sv
// Loadable, clearable, saturating 8-bit counter; tc flags count == term.
module contador_sessao (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic [7:0] term,
  output logic       tc
);

  logic [7:0] count_r;

  // Counter register: clear has priority over load, load over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (inc && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end
  end

  assign tc = (count_r == term);

endmodule

// File: rtl/controle_acesso.sv
// Session controller: login check, per-operation permission, inactivity timeout.
// Optional macro ACESSO_LOCKOUT_EN adds the failed-login lockout (LOCKED state).
module controle_acesso
  import acesso_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYC    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       login_req,
  input  logic [2:0] perfil,
  input  logic       logout_req,
  input  logic       op_req,
  input  logic [1:0] op_class,
  output logic       sessao_ativa,
  output logic [2:0] perfil_ativo,
  output logic       grant,
  output logic       deny,
  output logic       login_ok,
  output logic       login_fail,
  output logic       timeout,
  output logic       lockout,
  output logic [1:0] estado
);

  localparam logic [7:0] TIMEOUT_TERM = 8'(TIMEOUT_CYC - 1);

  estado_t    state_r;
  logic [2:0] cand_r;
  logic [2:0] perfil_r;
  logic       sessao_r, grant_r, deny_r, ok_r, fail_r, timeout_r;
  logic       timer_clr_s;
  logic       timer_tc_s;

  // Inactivity timer restarts on any activity and whenever the session is not open.
  always_comb begin
    timer_clr_s = 1'b0;
    if ((state_r != ST_ACTIVE) || op_req || logout_req || timer_tc_s) begin
      timer_clr_s = 1'b1;
    end else begin
      timer_clr_s = 1'b0;
    end
  end

  contador_sessao u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr_s),
    .load     (1'b0),
    .load_val (8'd0),
    .inc      (1'b1),
    .term     (TIMEOUT_TERM),
    .tc       (timer_tc_s)
  );

`ifdef ACESSO_LOCKOUT_EN
  localparam logic [7:0] LOCK_TERM = 8'(LOCK_CYC - 1);

  logic [2:0] fail_cnt_r;
  logic [2:0] fail_next_s;
  logic       lockout_r;
  logic       lock_clr_s;
  logic       lock_tc_s;

  // Saturating next value of the failed-login counter and lock timer control.
  always_comb begin
    fail_next_s = fail_cnt_r;
    lock_clr_s  = 1'b0;
    if (fail_cnt_r == 3'd7) begin
      fail_next_s = 3'd7;
    end else begin
      fail_next_s = fail_cnt_r + 3'd1;
    end
    if ((state_r != ST_LOCKED) || lock_tc_s) begin
      lock_clr_s = 1'b1;
    end else begin
      lock_clr_s = 1'b0;
    end
  end

  contador_sessao u_lock (
    .clk      (clk),
    .reset    (reset),
    .clr      (lock_clr_s),
    .load     (1'b0),
    .load_val (8'd0),
    .inc      (1'b1),
    .term     (LOCK_TERM),
    .tc       (lock_tc_s)
  );

  assign lockout = lockout_r;
`else
  assign lockout = 1'b0;
`endif

  // Main FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cand_r    <= PERFIL_NONE;
      perfil_r  <= PERFIL_NONE;
      sessao_r  <= 1'b0;
      grant_r   <= 1'b0;
      deny_r    <= 1'b0;
      ok_r      <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
`ifdef ACESSO_LOCKOUT_EN
      fail_cnt_r <= 3'd0;
      lockout_r  <= 1'b0;
`endif
    end else begin
      grant_r   <= 1'b0;
      deny_r    <= 1'b0;
      ok_r      <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (login_req) begin
            cand_r  <= perfil;
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (perfil_valido(cand_r)) begin
            state_r  <= ST_ACTIVE;
            ok_r     <= 1'b1;
            sessao_r <= 1'b1;
            perfil_r <= cand_r;
`ifdef ACESSO_LOCKOUT_EN
            fail_cnt_r <= 3'd0;
`endif
          end else begin
            fail_r <= 1'b1;
`ifdef ACESSO_LOCKOUT_EN
            fail_cnt_r <= fail_next_s;
            if (fail_next_s >= 3'(MAX_FAIL)) begin
              state_r   <= ST_LOCKED;
              lockout_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
`else
            state_r <= ST_IDLE;
`endif
          end
        end
        ST_ACTIVE: begin
          // Logout beats op_req, and op_req beats timer expiry.
          if (logout_req) begin
            state_r  <= ST_IDLE;
            sessao_r <= 1'b0;
            perfil_r <= PERFIL_NONE;
          end else if (op_req) begin
            grant_r <= permissao(perfil_r, op_class);
            deny_r  <= !permissao(perfil_r, op_class);
          end else if (timer_tc_s) begin
            state_r   <= ST_IDLE;
            sessao_r  <= 1'b0;
            perfil_r  <= PERFIL_NONE;
            timeout_r <= 1'b1;
          end
        end
        ST_LOCKED: begin
`ifdef ACESSO_LOCKOUT_EN
          if (lock_tc_s) begin
            state_r    <= ST_IDLE;
            lockout_r  <= 1'b0;
            fail_cnt_r <= 3'd0;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign sessao_ativa = sessao_r;
  assign perfil_ativo = perfil_r;
  assign grant        = grant_r;
  assign deny         = deny_r;
  assign login_ok     = ok_r;
  assign login_fail   = fail_r;
  assign timeout      = timeout_r;
  assign estado       = state_r;

endmodule

// File: tb/tb_controle_acesso.sv
// Directed, table-driven bench for controle_acesso (default parameters).
module tb_controle_acesso;

  logic       clk = 1'b0;
  logic       reset;
  logic       login_req, logout_req, op_req;
  logic [2:0] perfil;
  logic [1:0] op_class;
  logic       sessao_ativa, grant, deny, login_ok, login_fail, timeout, lockout;
  logic [2:0] perfil_ativo;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;
  int n_lock;

  // flag order: sessao, grant, deny, login_ok, login_fail, timeout, lockout
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] SS = 7'b1000000;
  localparam logic [6:0] GR = 7'b0100000;
  localparam logic [6:0] DN = 7'b0010000;
  localparam logic [6:0] OK = 7'b0001000;
  localparam logic [6:0] FL = 7'b0000100;
  localparam logic [6:0] TO = 7'b0000010;
  localparam logic [6:0] LO = 7'b0000001;

  typedef struct packed {
    logic        login;
    logic [2:0]  pf;
    logic        logout;
    logic        op;
    logic [1:0]  cls;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [27];

  always #5 clk = ~clk;

  controle_acesso #(.TIMEOUT_CYC(16), .MAX_FAIL(3), .LOCK_CYC(32)) dut (
    .clk(clk), .reset(reset), .login_req(login_req), .perfil(perfil),
    .logout_req(logout_req), .op_req(op_req), .op_class(op_class),
    .sessao_ativa(sessao_ativa), .perfil_ativo(perfil_ativo), .grant(grant),
    .deny(deny), .login_ok(login_ok), .login_fail(login_fail),
    .timeout(timeout), .lockout(lockout), .estado(estado)
  );

  wire [11:0] obs = {estado, perfil_ativo, sessao_ativa, grant, deny,
                     login_ok, login_fail, timeout, lockout};

  function automatic logic [11:0] ex(input logic [1:0] st, input logic [2:0] pf,
                                     input logic [6:0] fl);
    return {st, pf, fl};
  endfunction

  function automatic vec_t mk(input logic l, input logic [2:0] p, input logic lo,
                              input logic o, input logic [1:0] c, input logic [11:0] e);
    vec_t v;
    v.login = l; v.pf = p; v.logout = lo; v.op = o; v.cls = c; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] e);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: got estado=%b perfil=%b flags=%b, expected estado=%b perfil=%b flags=%b",
               name, obs[11:10], obs[9:7], obs[6:0], e[11:10], e[9:7], e[6:0]);
    end
  endtask

  task automatic drive(input logic l, input logic [2:0] p, input logic lo,
                       input logic o, input logic [1:0] c);
    login_req = l; perfil = p; logout_req = lo; op_req = o; op_class = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic login_seq(input logic [2:0] p, input string name);
    drive(1'b1, p, 1'b0, 1'b0, 2'd0);
    tick();
    check({name, "_check"}, ex(2'b01, 3'b000, F0));
    drive(1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
    tick();
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 3'b110, 1'b0, 1'b0, 2'd0, ex(2'b01, 3'b000, F0));
    vecs[1]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, ex(2'b10, 3'b110, SS | OK));
    vecs[2]  = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd2, ex(2'b10, 3'b110, SS | GR));
    vecs[3]  = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd3, ex(2'b10, 3'b110, SS | DN));
    vecs[4]  = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, ex(2'b10, 3'b110, SS | GR));
    vecs[5]  = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd1, ex(2'b10, 3'b110, SS | GR));
    vecs[6]  = mk(1'b1, 3'b101, 1'b0, 1'b0, 2'd0, ex(2'b10, 3'b110, SS));
    vecs[7]  = mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd0, ex(2'b00, 3'b000, F0));
    vecs[8]  = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, ex(2'b00, 3'b000, F0));
    vecs[9]  = mk(1'b1, 3'b011, 1'b0, 1'b0, 2'd0, ex(2'b01, 3'b000, F0));
    vecs[10] = mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, ex(2'b10, 3'b011, SS | OK));
    vecs[11] = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, ex(2'b10, 3'b011, SS | GR));
    vecs[12] = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd1, ex(2'b10, 3'b011, SS | DN));
    vecs[13] = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd2, ex(2'b10, 3'b011, SS | DN));
    vecs[14] = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd3, ex(2'b10, 3'b011, SS | DN));
    vecs[15] = mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, ex(2'b00, 3'b000, F0));
    vecs[16] = mk(1'b1, 3'b101, 1'b0, 1'b0, 2'd0, ex(2'b01, 3'b000, F0));
    vecs[17] = mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, ex(2'b10, 3'b101, SS | OK));
    vecs[18] = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd3, ex(2'b10, 3'b101, SS | GR));
    vecs[19] = mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, ex(2'b00, 3'b000, F0));
    vecs[20] = mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, ex(2'b01, 3'b000, F0));
    vecs[21] = mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, ex(2'b00, 3'b000, FL));
    vecs[22] = mk(1'b1, 3'b100, 1'b0, 1'b0, 2'd0, ex(2'b01, 3'b000, F0));
    vecs[23] = mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, ex(2'b10, 3'b100, SS | OK));
    vecs[24] = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd2, ex(2'b10, 3'b100, SS | DN));
    vecs[25] = mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd1, ex(2'b10, 3'b100, SS | GR));
    vecs[26] = mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, ex(2'b00, 3'b000, F0));

    reset = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", ex(2'b00, 3'b000, F0));
    reset = 1'b0;
    tick();
    check("reset_release", ex(2'b00, 3'b000, F0));

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].login, vecs[i].pf, vecs[i].logout, vecs[i].op, vecs[i].cls);
      tick();
      check($sformatf("vec_%0d", i), vecs[i].exp);
    end

    // asynchronous reset in the middle of an ADM session
    login_seq(3'b101, "rst_login");
    check("rst_active", ex(2'b10, 3'b101, SS | OK));
    #2 reset = 1'b1;
    #1;
    check("rst_async", ex(2'b00, 3'b000, F0));
    tick();
    reset = 1'b0;
    tick();
    check("rst_after", ex(2'b00, 3'b000, F0));

    // inactivity timeout on the 16th idle edge
    login_seq(3'b100, "to_login");
    check("to_ok", ex(2'b10, 3'b100, SS | OK));
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("to_idle_%0d", i), ex(2'b10, 3'b100, SS));
    end
    tick();
    check("to_expire", ex(2'b00, 3'b000, TO));
    tick();
    check("to_pulse_end", ex(2'b00, 3'b000, F0));

    // op_req in the expiry cycle keeps the session and restarts the timer
    login_seq(3'b100, "to2_login");
    check("to2_ok", ex(2'b10, 3'b100, SS | OK));
    repeat (15) tick();
    check("to2_before", ex(2'b10, 3'b100, SS));
    drive(1'b0, 3'b000, 1'b0, 1'b1, 2'd0);
    tick();
    check("to2_op_wins", ex(2'b10, 3'b100, SS | GR));
    drive(1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
    repeat (15) tick();
    check("to2_restart", ex(2'b10, 3'b100, SS));
    tick();
    check("to2_expire", ex(2'b00, 3'b000, TO));

`ifdef ACESSO_LOCKOUT_EN
    for (int k = 0; k < 3; k++) begin
      login_seq(3'b111, $sformatf("lk_%0d", k));
      if (k < 2) check($sformatf("lk_fail_%0d", k), ex(2'b00, 3'b000, FL));
      else       check("lk_enter", ex(2'b11, 3'b000, FL | LO));
    end
    n_lock = 1;
    drive(1'b1, 3'b101, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 100; i++) begin
      tick();
      drive(1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
      if (lockout) n_lock++;
      else break;
    end
    checks++;
    if (n_lock != 32) begin
      errors++;
      $display("FAIL lock_len: got %0d cycles, expected 32", n_lock);
    end
    check("lk_exit", ex(2'b00, 3'b000, F0));
    login_seq(3'b101, "lk_relogin");
    check("lk_relogin_ok", ex(2'b10, 3'b101, SS | OK));
`else
    for (int k = 0; k < 5; k++) begin
      login_seq(3'b111, $sformatf("nl_%0d", k));
      check($sformatf("nl_fail_%0d", k), ex(2'b00, 3'b000, FL));
    end
    tick();
    check("nl_idle", ex(2'b00, 3'b000, F0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
